// File: rtl/bp_cfg_boot_sequencer.sv
// bp_cfg_boot_sequencer: writes freeze/hart-id/cache-mode/boot-NPC to every core, then unfreezes all.
// Define BP_CFG_SEQ_TIMEOUT_EN to add the ack watchdog and the ERROR state.
//
//   state     | meaning
//   IDLE      | waiting for start after reset
//   CFG       | writing the five boot registers of core_cnt
//   UNFREEZE  | clearing freeze on core_cnt
//   DRAIN     | all writes issued, waiting for outstanding acks
//   DONE      | sequence complete, done held until next start
//   ERROR     | ack watchdog expired (watchdog build only)
module bp_cfg_boot_sequencer #(
    parameter int num_core_p       = 4,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int vaddr_width_p    = 39,
    parameter int max_credits_p    = 4,
    parameter int timeout_p        = 1024,
    localparam int core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [vaddr_width_p-1:0]    boot_pc_i,
    input  logic [1:0]                  icache_mode_i,
    input  logic [1:0]                  dcache_mode_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_w_lp-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        ack_v_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o
);

    localparam int cred_w_lp = $clog2(max_credits_p + 1);

    if (num_core_p < 1 || max_credits_p < 1 || timeout_p < 2) begin : g_bad_params
        $error("bp_cfg_boot_sequencer: invalid parameter value");
    end

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_CFG, ST_UNFREEZE, ST_DRAIN, ST_DONE, ST_ERROR
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_CFG, ST_UNFREEZE, ST_DRAIN, ST_DONE
    } state_e;
`endif

    state_e                   state_r, state_n;
    logic [2:0]               reg_cnt_r;
    logic [core_w_lp-1:0]     core_cnt_r;
    logic [cred_w_lp-1:0]     credits_r, credits_n;
    logic [vaddr_width_p-1:0] boot_pc_r;
    logic [1:0]               icache_mode_r, dcache_mode_r;

    logic fire, ack_eff, last_core, start_ok, busy_state, wd_hit;

    assign fire       = cfg_v_o & cfg_ready_i;
    assign ack_eff    = ack_v_i & (credits_r != '0);
    assign last_core  = (core_cnt_r == core_w_lp'(num_core_p - 1));
    assign busy_state = (state_r == ST_CFG) || (state_r == ST_UNFREEZE) || (state_r == ST_DRAIN);

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    assign start_ok = start_i & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERROR));
`else
    assign start_ok = start_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
`endif

    always_comb begin
        credits_n = credits_r;
        if (fire && !ack_eff)
            credits_n = credits_r + cred_w_lp'(1);
        else if (!fire && ack_eff)
            credits_n = credits_r - cred_w_lp'(1);
    end

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    localparam int wd_w_lp = $clog2(timeout_p + 1);
    logic [wd_w_lp-1:0] wd_r, wd_n;

    // Any ack is proof of life; an empty credit pool has nothing to wait for.
    always_comb begin
        wd_n = '0;
        if (busy_state && !ack_v_i && credits_r != '0)
            wd_n = wd_r + wd_w_lp'(1);
    end

    assign wd_hit = busy_state && (wd_n == wd_w_lp'(timeout_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            wd_r <= '0;
        else if (start_ok)
            wd_r <= '0;
        else
            wd_r <= wd_n;
    end

    assign error_o = (state_r == ST_ERROR);
`else
    assign wd_hit  = 1'b0;
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_r <= ST_IDLE;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            ST_IDLE, ST_DONE: if (start_i) state_n = ST_CFG;
            ST_CFG:           if (fire && reg_cnt_r == 3'd4 && last_core) state_n = ST_UNFREEZE;
            ST_UNFREEZE:      if (fire && last_core) state_n = ST_DRAIN;
            ST_DRAIN:         if (credits_r == '0) state_n = ST_DONE;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
            ST_ERROR:         if (start_i) state_n = ST_CFG;
`endif
            default:          state_n = ST_IDLE;
        endcase
`ifdef BP_CFG_SEQ_TIMEOUT_EN
        if (wd_hit)
            state_n = ST_ERROR;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            reg_cnt_r     <= '0;
            core_cnt_r    <= '0;
            credits_r     <= '0;
            boot_pc_r     <= '0;
            icache_mode_r <= '0;
            dcache_mode_r <= '0;
        end else if (start_ok) begin
            reg_cnt_r     <= '0;
            core_cnt_r    <= '0;
            credits_r     <= '0;
            boot_pc_r     <= boot_pc_i;
            icache_mode_r <= icache_mode_i;
            dcache_mode_r <= dcache_mode_i;
        end else begin
            credits_r <= credits_n;
            if (fire) begin
                if (state_r == ST_CFG && reg_cnt_r != 3'd4) begin
                    reg_cnt_r <= reg_cnt_r + 3'd1;
                end else begin
                    reg_cnt_r  <= '0;
                    core_cnt_r <= last_core ? '0 : core_cnt_r + core_w_lp'(1);
                end
            end
        end
    end

    always_comb begin
        cfg_v_o    = 1'b0;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_r)
            ST_CFG: begin
                cfg_v_o    = (credits_r < cred_w_lp'(max_credits_p));
                busy_o     = 1'b1;
                cfg_core_o = core_cnt_r;
                unique case (reg_cnt_r)
                    3'd0: begin
                        cfg_addr_o = cfg_addr_width_p'(16'h0002);
                        cfg_data_o = cfg_data_width_p'(1);
                    end
                    3'd1: begin
                        cfg_addr_o = cfg_addr_width_p'(16'h0004);
                        cfg_data_o = cfg_data_width_p'(core_cnt_r);
                    end
                    3'd2: begin
                        cfg_addr_o = cfg_addr_width_p'(16'h0006);
                        cfg_data_o = cfg_data_width_p'(icache_mode_r);
                    end
                    3'd3: begin
                        cfg_addr_o = cfg_addr_width_p'(16'h0007);
                        cfg_data_o = cfg_data_width_p'(dcache_mode_r);
                    end
                    default: begin
                        cfg_addr_o = cfg_addr_width_p'(16'h0008);
                        cfg_data_o = cfg_data_width_p'(boot_pc_r);
                    end
                endcase
            end
            ST_UNFREEZE: begin
                cfg_v_o    = (credits_r < cred_w_lp'(max_credits_p));
                busy_o     = 1'b1;
                cfg_core_o = core_cnt_r;
                cfg_addr_o = cfg_addr_width_p'(16'h0002);
            end
            ST_DRAIN: busy_o = 1'b1;
            ST_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    // An ack with nothing outstanding is dropped; flag it without stopping simulation.
    always @(posedge clk_i) begin
        if (!reset_i)
            assert (!(ack_v_i && credits_r == '0))
            else $warning("bp_cfg_boot_sequencer: stray ack ignored");
    end
`endif

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Directed bench for bp_cfg_boot_sequencer: 2 cores, 2 credits, 16-cycle watchdog when enabled.
`timescale 1ns/1ps
module tb_bp_cfg_boot_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [38:0] boot_pc_i = 39'h0080000000;
    logic [1:0]  icache_mode_i = 2'b01;
    logic [1:0]  dcache_mode_i = 2'b10;
    logic        cfg_v_o;
    logic        cfg_ready_i = 1'b1;
    logic [0:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [63:0] cfg_data_o;
    logic        ack_v_i = 1'b0;
    logic        busy_o, done_o, error_o;

    bp_cfg_boot_sequencer #(
        .num_core_p(2), .cfg_addr_width_p(16), .cfg_data_width_p(64),
        .vaddr_width_p(39), .max_credits_p(2), .timeout_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .boot_pc_i(boot_pc_i),
        .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i),
        .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_core_o(cfg_core_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .ack_v_i(ack_v_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic auto_ack = 1'b0, man_ack = 1'b0, toggle_rdy = 1'b0, fire_n = 1'b0;

    logic [0:0]  log_core[$];
    logic [15:0] log_addr[$];
    logic [63:0] log_data[$];
    int          hold_viol = 0;
    logic        prev_hold = 1'b0;
    logic [80:0] prev_bus = '0;

    logic [0:0]  exp_core[12];
    logic [15:0] exp_addr[12];
    logic [63:0] exp_data[12];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Log every fire and watch that a stalled request keeps its payload.
    always @(negedge clk_i) begin
        fire_n = cfg_v_o & cfg_ready_i;
        if (fire_n) begin
            log_core.push_back(cfg_core_o);
            log_addr.push_back(cfg_addr_o);
            log_data.push_back(cfg_data_o);
        end
        if (prev_hold && !reset_i && (!cfg_v_o || {cfg_core_o, cfg_addr_o, cfg_data_o} != prev_bus))
            hold_viol++;
        prev_hold = cfg_v_o & ~cfg_ready_i & ~reset_i;
        prev_bus  = {cfg_core_o, cfg_addr_o, cfg_data_o};
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        ack_v_i = (auto_ack & fire_n) | man_ack;
        if (toggle_rdy)
            cfg_ready_i = ~cfg_ready_i;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_o), 64'd1);
    endtask

    task automatic check_seq(input int base, input string tag);
        chk({tag, "_count"}, 64'(log_addr.size() - base), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < log_addr.size()) begin
                chk($sformatf("%s_w%0d_core_addr", tag, i),
                    64'({log_core[base+i], log_addr[base+i]}), 64'({exp_core[i], exp_addr[i]}));
                chk($sformatf("%s_w%0d_data", tag, i), log_data[base+i], exp_data[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb timeout");
    end

    initial begin
        int base;
        int n;
        exp_core = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1};
        exp_addr = '{16'h2, 16'h4, 16'h6, 16'h7, 16'h8,
                     16'h2, 16'h4, 16'h6, 16'h7, 16'h8, 16'h2, 16'h2};
        exp_data = '{64'd1, 64'd0, 64'd1, 64'd2, 64'h80000000,
                     64'd1, 64'd1, 64'd1, 64'd2, 64'h80000000, 64'd0, 64'd0};

        #1 reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 64'(cfg_v_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_core_addr", 64'({cfg_core_o, cfg_addr_o}), 64'd0);
        chk("rst_data", cfg_data_o, 64'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        tick();
        chk("idle_busy", 64'(busy_o), 64'd0);

        // Full sequence, ready always high, ack one cycle after each fire.
        auto_ack = 1'b1;
        base = log_addr.size();
        do_start();
        chk("t1_first_valid", 64'(cfg_v_o), 64'd1);
        chk("t1_first_busy", 64'(busy_o), 64'd1);
        chk("t1_first_addr", 64'(cfg_addr_o), 64'h2);
        wait_done(60, "t1_done");
        chk("t1_busy_low", 64'(busy_o), 64'd0);
        check_seq(base, "t1");
        repeat (3) tick();
        chk("t1_done_held", 64'(done_o), 64'd1);
        chk("t1_no_extra", 64'(log_addr.size() - base), 64'd12);

        // Stray ack while idle in DONE must not disturb the credit count.
        auto_ack = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("stray_done_held", 64'(done_o), 64'd1);

        // Credit limit of 2 without acks.
        base = log_addr.size();
        do_start();
        chk("t2_done_drop", 64'(done_o), 64'd0);
        repeat (8) tick();
        chk("t2_two_fires", 64'(log_addr.size() - base), 64'd2);
        chk("t2_blocked", 64'(cfg_v_o), 64'd0);
        chk("t2_busy", 64'(busy_o), 64'd1);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (6) tick();
        chk("t2_one_more", 64'(log_addr.size() - base), 64'd3);
        chk("t2_blocked_again", 64'(cfg_v_o), 64'd0);
        // Ack held for two cycles: second ack coincides with a fire at credits=1.
        man_ack = 1'b1;
        tick();
        tick();
        man_ack = 1'b0;
        repeat (6) tick();
        chk("t2_same_cycle", 64'(log_addr.size() - base), 64'd5);

        @(posedge clk_i);
        #1 reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        ack_v_i = 1'b0;

        // Ready toggling every cycle.
        auto_ack = 1'b1;
        toggle_rdy = 1'b1;
        base = log_addr.size();
        do_start();
        wait_done(150, "t3_done");
        check_seq(base, "t3");
        toggle_rdy = 1'b0;
        cfg_ready_i = 1'b1;
        chk("t3_hold_stable", 64'(hold_viol), 64'd0);

        // Asynchronous reset at core 1 reg 2.
        base = log_addr.size();
        do_start();
        n = 0;
        while (log_addr.size() - base < 7 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_at_c1r2", 64'({cfg_core_o, cfg_addr_o}), 64'({1'b1, 16'h6}));
        #2 reset_i = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(cfg_v_o), 64'd0);
        chk("t4_rst_busy", 64'(busy_o), 64'd0);
        chk("t4_rst_core_addr", 64'({cfg_core_o, cfg_addr_o}), 64'd0);
        chk("t4_rst_data", cfg_data_o, 64'd0);
        tick();
        tick();
        reset_i = 1'b0;
        base = log_addr.size();
        do_start();
        chk("t4_restart_addr", 64'({cfg_core_o, cfg_addr_o}), 64'({1'b0, 16'h2}));
        chk("t4_restart_data", cfg_data_o, 64'd1);
        wait_done(60, "t4_done");
        check_seq(base, "t4");

`ifdef BP_CFG_SEQ_TIMEOUT_EN
        auto_ack = 1'b0;
        do_start();
        repeat (15) tick();
        chk("to_not_yet", 64'(error_o), 64'd0);
        tick();
        chk("to_error", 64'(error_o), 64'd1);
        chk("to_valid", 64'(cfg_v_o), 64'd0);
        chk("to_busy", 64'(busy_o), 64'd0);
        do_start();
        chk("to_error_clear", 64'(error_o), 64'd0);
        chk("to_restart_valid", 64'(cfg_v_o), 64'd1);
        chk("to_restart_addr", 64'(cfg_addr_o), 64'h2);
`else
        chk("error_tied_low", 64'(error_o), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_cfg_boot_sequencer.md
Name: bp_cfg_boot_sequencer

Overview:
- Post-reset controller that configures every core tile of the processor configuration selected at elaboration.
- Walks cores 0..num_core_p-1 and writes the boot-configuration registers to each over a valid/ready config-write bus. Configuration is freeze, hart id, I$/D$ mode and boot NPC.
- After all cores are configured, runs a second pass that releases freeze on each core, then asserts done.
- Tracks outstanding writes with a credit counter fed by write acks. Sits between the host/boot interface and the per-tile config links.

Parameters:
- num_core_p, 4, number of cores (cc_x_dim*cc_y_dim of the chosen config); must be ≥1.
- cfg_addr_width_p, 16, config register address width.
- cfg_data_width_p, 64, config write data width.
- vaddr_width_p, 39, boot PC width.
- max_credits_p, 4, maximum outstanding unacked writes; must be ≥1.
- timeout_p, 1024, ack timeout in cycles (optional feature only).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  begin sequence; sampled only in IDLE or DONE.
- boot_pc_i  in  vaddr_width_p  boot NPC; captured on accepted start.
- icache_mode_i  in  2  I$ mode; captured on accepted start.
- dcache_mode_i  in  2  D$ mode; captured on accepted start.
- cfg_v_o  out  1  write valid.
- cfg_ready_i  in  1  write ready.
- cfg_core_o  out  clog2(num_core_p) (min 1)  destination core.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
- ack_v_i  in  1  one write acknowledged.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete.
- error_o  out  1  ack timeout (optional feature only; tied 0 otherwise).

Behaviour:
- States: IDLE, CFG, UNFREEZE, DRAIN, DONE (+ERROR with optional feature). Reset forces IDLE, all counters 0. Outputs at reset: cfg_v_o=0, busy_o=0, done_o=0, error_o=0, addr/data/core=0.
- Fire = cfg_v_o & cfg_ready_i.
- cfg_v_o=1 only in CFG/UNFREEZE and when credits < max_credits_p. Address, data and core are combinational from state and counters. They are stable while valid is held.
- CFG per core, reg_cnt 0..4:
  - 0: addr 0x0002, data 1 (freeze).
  - 1: addr 0x0004, data core_cnt (hart id).
  - 2: addr 0x0006, data icache_mode.
  - 3: addr 0x0007, data dcache_mode.
  - 4: addr 0x0008, data boot_pc.
- Fire advances reg_cnt. On reg_cnt 4 it wraps to 0 and increments core_cnt. Fire at reg 4 of the last core clears core_cnt and moves to UNFREEZE.
- UNFREEZE: addr 0x0002, data 0 per core in ascending order. Fire on the last core moves to DRAIN.
- DRAIN: when credits==0, move to DONE. Moving to DONE on the same cycle as the final ack is allowed.
- Total writes per sequence = 6*num_core_p.
- Credits: +1 on fire, -1 on ack_v_i. Both in the same cycle → unchanged. ack_v_i with credits==0 is ignored (simulation assertion). credits==max_credits_p blocks cfg_v_o for that cycle.
- busy_o=1 in CFG/UNFREEZE/DRAIN.
- done_o=1 in DONE, held until the next start_i; start_i in DONE restarts at CFG with done_o dropping the next cycle.
- start_i in CFG/UNFREEZE/DRAIN is ignored.
- Accepted start: captures inputs, zeroes counters, moves to CFG; first cfg_v_o the following cycle.
- num_core_p=1: core width is 1 bit, core always 0.
- Asynchronous reset mid-sequence aborts immediately to IDLE. Outstanding acks after reset are ignored because credits==0.

Optional Feature:
- Macro BP_CFG_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on any ack_v_i or when credits==0.
  - Otherwise it increments each cycle credits>0.
  - Reaching timeout_p-1 moves to ERROR: error_o=1, cfg_v_o=0, busy_o=0.
  - ERROR is left only via reset or start_i, which restarts CFG and clears error_o.
- Undefined: no watchdog, no ERROR state, error_o tied 0.

Test Plan:
- num_core_p=2, cfg_ready_i=1, acks returned 1 cycle after each fire, boot_pc_i=0x80000000 → 12 writes in order:
  - (c0,2,1),(c0,4,0),(c0,6,m),(c0,7,m),(c0,8,0x80000000)
  - then the same five for c1 with hart id 1
  - then (c0,2,0),(c1,2,0)
  - done_o=1 after the last ack, busy_o=0.
- max_credits_p=2, no acks → exactly 2 fires then cfg_v_o=0. A single ack → exactly one more fire.
- cfg_ready_i toggled 0/1 every cycle → addr/data/core unchanged while valid and not ready. Sequence order identical to the first test.
- Fire and ack in the same cycle with credits=1 → credits stay 1. Stray ack at credits=0 → no change, assertion fires.
- Reset asserted mid-CFG at core 1 reg 2 → outputs 0 asynchronously. New start_i restarts from (c0,2,1).
- BP_CFG_SEQ_TIMEOUT_EN, timeout_p=16, ack withheld after the first fire → error_o=1 on the cycle the count reaches 15, cfg_v_o=0. start_i → error_o=0 and the sequence restarts.
